ahb2apb_bridge_multi: RTL and testbench
=======================================

# ahb2apb_bridge_multi

Parametrised AHB-Lite slave to multi-slave APB bridge. It sits between the AHB fabric and up to NUM_SLV APB peripherals. It decodes one slave select per transfer from the AHB address and runs one APB transfer per AHB transfer, with no pipelining across transfers. It converts APB slave errors, unmapped addresses, unsupported sizes and APB timeouts into a two-cycle AHB ERROR response.

## Interface
- ADDR_W, 32, address width of haddrs and paddr
- DATA_W, 32, data width; 32 or 64
- NUM_SLV, 4, number of APB slaves; 1..16
- DEC_LSB, 12, lowest haddrs bit of the slave index field
- DEC_W, 4, width of the slave index field; 2^DEC_W >= NUM_SLV
- TIMEOUT, 256, maximum ACCESS cycles before abort; 0 disables the timeout
- clock  in  1  bridge clock; all logic on its rising edge
- reset  in  1  synchronous, active-low reset
- hsels  in  1  AHB slave select
- haddrs  in  ADDR_W  AHB address
- hwrites  in  1  1 = write
- htranss  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hsizes  in  3  transfer size
- hbursts  in  3  burst type; no effect on behaviour
- hreadys  in  1  AHB bus ready
- hwdatas  in  DATA_W  AHB write data; valid in the data phase
- hreadyouts  out  1  bridge ready
- hresps  out  2  OKAY=00, ERROR=01
- hrdatas  out  DATA_W  read data
- psel  out  NUM_SLV  one-hot APB select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  NUM_SLV*DATA_W  per-slave read data; slave k occupies bits [k*DATA_W +: DATA_W]
- pready  in  NUM_SLV  per-slave ready
- pslverr  in  NUM_SLV  per-slave error

## Operation
- **Reset values.** While reset=0 at a clock edge, the bridge returns to IDLE. Outputs take these values from the next edge:
  - hreadyouts=1, hresps=00, hrdatas=0
  - psel=0, penable=0, paddr=0, pwrite=0, pwdata=0
  - timeout counter=0
  - This holds mid-transfer; the bridge never completes an aborted transfer.
- **Accept.** In state IDLE or ERR2, a transfer is accepted when hsels & hreadys & htranss[1]. On accept the bridge registers:
  - haddrs into paddr
  - hwrites into pwrite
  - the slave index idx = haddrs[DEC_LSB +: DEC_W]
  - BUSY and IDLE transfers are ignored, with OKAY and no state change.
- **Next state after accept:**
  - idx >= NUM_SLV, or hsizes > log2(DATA_W/8): ERR1. No APB activity occurs.
  - Otherwise, read: SETUP.
  - Otherwise, write: WDAT.
- **WDAT** (1 cycle): latch hwdatas into pwdata; go to SETUP.
- **SETUP** (1 cycle): psel[idx]=1, penable=0; go to ACCESS.
- **ACCESS:** psel[idx]=1, penable=1. The state holds until one of the following:
  - pready[idx]=1 and pslverr[idx]=0: go to IDLE. For reads, hrdatas is registered from the idx slice of prdata.
  - pready[idx]=1 and pslverr[idx]=1: go to ERR1; hrdatas is unchanged.
  - The counter reaches TIMEOUT with TIMEOUT≠0: go to ERR1. psel and penable drop at the same edge.
- **Error response:**
  - ERR1: hresps=01, hreadyouts=0.
  - ERR2: hresps=01, hreadyouts=1. Go to IDLE, or accept a new transfer as described above.
- **Ready and select rules:**
  - hreadyouts = 1 only in IDLE and ERR2.
  - At most one psel bit is high at any time; psel and penable are 0 outside SETUP and ACCESS.
- **Stability:** paddr, pwrite and pwdata hold their value from SETUP through the end of ACCESS. They keep their last value in IDLE.
- **Timeout counter:**
  - Clears on entry to ACCESS.
  - Increments on each ACCESS cycle with pready[idx]=0.
  - Width is clog2(TIMEOUT+1).
  - pready on the same cycle the counter reaches TIMEOUT wins: OKAY, or ERROR if pslverr is set.
- pready and pslverr of non-selected slaves are ignored.

## Timing
- **Read, zero wait states.** Accept at cycle N.
  - N+1: SETUP.
  - N+2: ACCESS with pready=1.
  - N+3: hreadyouts=1 and hrdatas valid. AHB sees 2 wait states.
- **Write, zero wait states.** Accept at cycle N.
  - N+1: WDAT.
  - N+2: SETUP.
  - N+3: ACCESS.
  - N+4: hreadyouts=1. AHB sees 3 wait states.
- Each APB wait state adds one cycle.
- **Unmapped address or bad size:** accept at N, ERR1 at N+1, ERR2 at N+2.
- **Back-to-back transfers:** a transfer presented in the completion cycle (IDLE with hreadyouts=1) is accepted immediately.

## Test plan
- **Read, slave 2.** Stimulus: NUM_SLV=4; read at haddrs=0x0000_2010; slave 2 drives prdata=0xDEAD_BEEF with pready=1 in its first ACCESS cycle. Required: psel=0100 at N+1..N+2, penable=1 at N+2, hrdatas=0xDEAD_BEEF with hresps=00 at N+3.
- **Write, slave 0 with 3 wait states.** Stimulus: write of 0x1234_5678 to 0x0000_0004; slave 0 holds pready=0 for 3 ACCESS cycles. Required: pwdata=0x1234_5678 stable from SETUP through ACCESS, hreadyouts=1 at N+7.
- **APB slave error.** Stimulus: slave 1 returns pslverr=1 with pready=1. Required: ERR1 (hreadyouts=0, hresps=01), then ERR2 (hreadyouts=1, hresps=01), then IDLE.
- **Unmapped address.** Stimulus: haddrs=0x0000_5000 with NUM_SLV=4. Required: psel stays 0000; ERROR at N+1 and N+2.
- **Timeout.** Stimulus: TIMEOUT=8; slave 3 never asserts pready. Required: psel and penable drop after 8 ACCESS cycles, followed by a two-cycle ERROR.
- **Reset during ACCESS.** Stimulus: reset=0 for one edge while in ACCESS. Required: all outputs at reset values at the next edge; the next transfer completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge_multi_if.sv
// Bus bundle for the AHB-Lite to multi-slave APB bridge: AHB slave side plus APB master side.
// The bridge connects through 'slave'; the surrounding fabric and peripherals use 'master'.
interface ahb2apb_bridge_multi_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4
) ();

  // AHB-Lite
  logic                      hsels;
  logic [ADDR_W-1:0]         haddrs;
  logic                      hwrites;
  logic [1:0]                htranss;
  logic [2:0]                hsizes;
  logic [2:0]                hbursts;
  logic                      hreadys;
  logic [DATA_W-1:0]         hwdatas;
  logic                      hreadyouts;
  logic [1:0]                hresps;
  logic [DATA_W-1:0]         hrdatas;

  // APB
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic [ADDR_W-1:0]         paddr;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport slave (
    input  hsels, haddrs, hwrites, htranss, hsizes, hbursts, hreadys, hwdatas,
    output hreadyouts, hresps, hrdatas,
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsels, haddrs, hwrites, htranss, hsizes, hbursts, hreadys, hwdatas,
    input  hreadyouts, hresps, hrdatas,
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ahb2apb_bridge_multi.sv
// AHB-Lite slave to multi-slave APB bridge. One APB transfer per AHB transfer; slave errors,
// unmapped addresses, oversize transfers and APB timeouts become a two-cycle AHB ERROR.
module ahb2apb_bridge_multi #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned DEC_LSB = 12,
  parameter int unsigned DEC_W   = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input logic                    clock,
  input logic                    reset,
  ahb2apb_bridge_multi_if.slave  bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDAT   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [NUM_SLV-1:0] r_sel_oh;
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic [DATA_W-1:0]  r_hrdata;
  logic [CNT_W-1:0]   r_cnt;

  logic [DEC_W-1:0]   w_idx;
  logic [NUM_SLV-1:0] w_dec_oh;
  logic               w_unmapped;
  logic               w_bad_size;
  logic               w_can_accept;
  logic               w_accept;
  logic               w_sel_ready;
  logic               w_sel_err;
  logic               w_timeout;
  logic [DATA_W-1:0]  w_sel_rdata;

  assign w_idx        = bus.haddrs[DEC_LSB +: DEC_W];
  assign w_bad_size   = (bus.hsizes > 3'(MAX_SIZE));
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && bus.hsels && bus.hreadys && bus.htranss[1];

  // Index values at or above NUM_SLV leave the one-hot empty and flag the address as unmapped.
  always_comb begin
    w_dec_oh   = '0;
    w_unmapped = 1'b1;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (w_idx == DEC_W'(k)) begin
        w_dec_oh[k] = 1'b1;
        w_unmapped  = 1'b0;
      end
    end
  end

  assign w_sel_ready = |(bus.pready & r_sel_oh);
  assign w_sel_err   = |(bus.pslverr & r_sel_oh);
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_sel_oh[k]) w_sel_rdata |= bus.prdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (!w_accept)                     w_state_nxt = ST_IDLE;
        else if (w_unmapped || w_bad_size) w_state_nxt = ST_ERR1;
        else if (bus.hwrites)              w_state_nxt = ST_WDAT;
        else                               w_state_nxt = ST_SETUP;
      end
      ST_WDAT:  w_state_nxt = ST_SETUP;
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // A ready response on the last allowed cycle beats the timeout.
        if (w_sel_ready)    w_state_nxt = w_sel_err ? ST_ERR1 : ST_IDLE;
        else if (w_timeout) w_state_nxt = ST_ERR1;
      end
      ST_ERR1:  w_state_nxt = ST_ERR2;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_sel_oh <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_hrdata <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_paddr  <= bus.haddrs;
        r_pwrite <= bus.hwrites;
        r_sel_oh <= w_dec_oh;
      end
      if (r_state == ST_WDAT) r_pwdata <= bus.hwdatas;
      if (r_state == ST_SETUP) begin
        r_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !w_sel_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_ACCESS) && w_sel_ready && !w_sel_err && !r_pwrite) begin
        r_hrdata <= w_sel_rdata;
      end
    end
  end

  assign bus.hreadyouts = w_can_accept;
  assign bus.hresps     = {1'b0, (r_state == ST_ERR1) || (r_state == ST_ERR2)};
  assign bus.hrdatas    = r_hrdata;
  assign bus.psel       = ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) ? r_sel_oh : '0;
  assign bus.penable    = (r_state == ST_ACCESS);
  assign bus.paddr      = r_paddr;
  assign bus.pwrite     = r_pwrite;
  assign bus.pwdata     = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge_multi.sv
// Self-checking bench for ahb2apb_bridge_multi: behavioural APB slaves plus a scoreboard of
// expected AHB completions (response, read data, latency in clock edges after accept).
module tb_ahb2apb_bridge_multi;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [31:0] exp_hrdata = '0;

  logic [31:0] rdata_cfg [NS];
  int          wait_cfg  [NS];
  bit          err_cfg   [NS];
  bit          never_cfg [NS];
  int          acc_cnt = 0;

  ahb2apb_bridge_multi_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  ahb2apb_bridge_multi #(
    .ADDR_W (AW), .DATA_W (DW), .NUM_SLV (NS), .DEC_LSB (12), .DEC_W (4), .TIMEOUT (TO)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // APB slaves: unselected ones shout ready+error, which the bridge must ignore.
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      bus.prdata[k*DW +: DW] = rdata_cfg[k];
      if (bus.psel[k]) begin
        if (bus.penable && !never_cfg[k] && acc_cnt >= wait_cfg[k]) begin
          bus.pready[k] = 1'b1; bus.pslverr[k] = err_cfg[k];
        end else begin
          bus.pready[k] = 1'b0; bus.pslverr[k] = 1'b1;
        end
      end else begin
        bus.pready[k] = 1'b1; bus.pslverr[k] = 1'b1;
      end
    end
    if (bus.psel != 0 && bus.penable) acc_cnt++;
    else acc_cnt = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one transfer from a negedge and returns at the negedge where hreadyouts is 1.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      input logic [2:0] size, output int lat, output logic [1:0] resp,
                      output logic [31:0] rdata, output int acc, output logic [NS-1:0] psel_or,
                      output logic [NS-1:0] psel_n1, output bit err1, output bit stable,
                      output bit onehot, output bit tmo);
    logic [31:0] a0, d0;
    logic        w0;
    bit          seen;
    bus.hsels = 1'b1; bus.haddrs = addr; bus.hwrites = wr; bus.htranss = 2'b10;
    bus.hsizes = size; bus.hbursts = 3'b000; bus.hreadys = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.hsels = 1'b0; bus.htranss = 2'b00; bus.hwdatas = wdata;
    lat = 1; acc = 0; psel_or = '0; err1 = 0; stable = 1; onehot = 1; tmo = 0; seen = 0;
    psel_n1 = bus.psel; a0 = '0; d0 = '0; w0 = 1'b0;
    forever begin
      if ($countones(bus.psel) > 1) onehot = 0;
      psel_or |= bus.psel;
      if (bus.psel != 0 && bus.penable) acc++;
      if (bus.psel != 0) begin
        if (!seen) begin
          a0 = bus.paddr; d0 = bus.pwdata; w0 = bus.pwrite; seen = 1;
        end else if (bus.paddr !== a0 || bus.pwdata !== d0 || bus.pwrite !== w0) begin
          stable = 0;
        end
      end
      if (!bus.hreadyouts && bus.hresps == 2'b01) err1 = 1;
      if (bus.hreadyouts) break;
      if (lat >= 200) begin tmo = 1; break; end
      @(posedge clk); @(negedge clk);
      if (lat == 1) bus.hwdatas = ~wdata;
      lat++;
    end
    resp = bus.hresps;
    rdata = bus.hrdatas;
  endtask

  task automatic test_reset();
    bus.hsels = 0; bus.haddrs = '0; bus.hwrites = 0; bus.htranss = 2'b00; bus.hsizes = 3'd2;
    bus.hbursts = 0; bus.hreadys = 1; bus.hwdatas = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (bus.hreadyouts !== 1'b1) begin n_err++; $display("FAIL rst_hready: got %b want 1", bus.hreadyouts); end
    n_cmp++; if (bus.hresps !== 2'b00) begin n_err++; $display("FAIL rst_hresp: got %b want 00", bus.hresps); end
    n_cmp++; if (bus.hrdatas !== 32'h0) begin n_err++; $display("FAIL rst_hrdata: got %h want 0", bus.hrdatas); end
    n_cmp++; if (bus.psel !== 4'b0) begin n_err++; $display("FAIL rst_psel: got %b want 0000", bus.psel); end
    n_cmp++; if (bus.penable !== 1'b0) begin n_err++; $display("FAIL rst_penable: got %b want 0", bus.penable); end
    n_cmp++; if (bus.paddr !== 32'h0) begin n_err++; $display("FAIL rst_paddr: got %h want 0", bus.paddr); end
    n_cmp++; if (bus.pwrite !== 1'b0) begin n_err++; $display("FAIL rst_pwrite: got %b want 0", bus.pwrite); end
    n_cmp++; if (bus.pwdata !== 32'h0) begin n_err++; $display("FAIL rst_pwdata: got %h want 0", bus.pwdata); end
  endtask

  task automatic test_busy_idle();
    bus.hsels = 1; bus.haddrs = 32'h0000_2000; bus.htranss = 2'b01; bus.hreadys = 1;
    @(posedge clk); @(negedge clk);
    bus.hsels = 0; bus.htranss = 2'b00;
    n_cmp++; if (bus.hreadyouts !== 1'b1) begin n_err++; $display("FAIL busy_hready: got %b want 1", bus.hreadyouts); end
    n_cmp++; if (bus.psel !== 4'b0) begin n_err++; $display("FAIL busy_psel: got %b want 0000", bus.psel); end
    n_cmp++; if (bus.hresps !== 2'b00) begin n_err++; $display("FAIL busy_hresp: got %b want 00", bus.hresps); end
  endtask

  task automatic test_read_slave2();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    wait_cfg[2] = 0; err_cfg[2] = 0; rdata_cfg[2] = 32'hDEAD_BEEF;
    sb.push_back('{resp: 2'b00, rdata: 32'hDEAD_BEEF, lat: 3});
    exp_hrdata = 32'hDEAD_BEEF;
    xfer(32'h0000_2010, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (tmo) begin n_err++; $display("FAIL rd2_timeout: got no completion want completion"); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL rd2_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (resp !== e.resp) begin n_err++; $display("FAIL rd2_resp: got %b want %b", resp, e.resp); end
    n_cmp++; if (rd !== e.rdata) begin n_err++; $display("FAIL rd2_rdata: got %h want %h", rd, e.rdata); end
    n_cmp++; if (p1 !== 4'b0100) begin n_err++; $display("FAIL rd2_psel_setup: got %b want 0100", p1); end
    n_cmp++; if (po !== 4'b0100) begin n_err++; $display("FAIL rd2_psel_any: got %b want 0100", po); end
    n_cmp++; if (acc !== 1) begin n_err++; $display("FAIL rd2_access_cycles: got %0d want 1", acc); end
    n_cmp++; if (!oh) begin n_err++; $display("FAIL rd2_onehot: got multi-hot want one-hot"); end
  endtask

  task automatic test_write_wait();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    wait_cfg[0] = 3; err_cfg[0] = 0;
    sb.push_back('{resp: 2'b00, rdata: exp_hrdata, lat: 4 + 3});
    xfer(32'h0000_0004, 1, 32'h1234_5678, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL wr_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (resp !== e.resp) begin n_err++; $display("FAIL wr_resp: got %b want %b", resp, e.resp); end
    n_cmp++; if (rd !== e.rdata) begin n_err++; $display("FAIL wr_hrdata_kept: got %h want %h", rd, e.rdata); end
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL wr_access_cycles: got %0d want 4", acc); end
    n_cmp++; if (!st) begin n_err++; $display("FAIL wr_stable: got changing paddr/pwdata want stable"); end
    n_cmp++; if (bus.pwdata !== 32'h1234_5678) begin n_err++; $display("FAIL wr_pwdata: got %h want 12345678", bus.pwdata); end
    n_cmp++; if (bus.paddr !== 32'h4) begin n_err++; $display("FAIL wr_paddr: got %h want 4", bus.paddr); end
    n_cmp++; if (bus.pwrite !== 1'b1) begin n_err++; $display("FAIL wr_pwrite: got %b want 1", bus.pwrite); end
    n_cmp++; if (po !== 4'b0001) begin n_err++; $display("FAIL wr_psel: got %b want 0001", po); end
    wait_cfg[0] = 0;
  endtask

  task automatic test_slverr();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    wait_cfg[1] = 0; err_cfg[1] = 1; rdata_cfg[1] = 32'h0BAD_0BAD;
    sb.push_back('{resp: 2'b01, rdata: exp_hrdata, lat: 4});
    xfer(32'h0000_1000, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL slverr_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (resp !== e.resp) begin n_err++; $display("FAIL slverr_err2: got %b want %b", resp, e.resp); end
    n_cmp++; if (!e1) begin n_err++; $display("FAIL slverr_err1: got none want hresp=01 hready=0"); end
    n_cmp++; if (rd !== e.rdata) begin n_err++; $display("FAIL slverr_hrdata: got %h want %h", rd, e.rdata); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (bus.hresps !== 2'b00 || bus.hreadyouts !== 1'b1) begin
      n_err++; $display("FAIL slverr_idle: got hresp=%b hready=%b want 00/1", bus.hresps, bus.hreadyouts);
    end
    err_cfg[1] = 0;
  endtask

  task automatic test_unmapped();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    sb.push_back('{resp: 2'b01, rdata: exp_hrdata, lat: 2});
    xfer(32'h0000_5000, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL unmap_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (resp !== e.resp) begin n_err++; $display("FAIL unmap_resp: got %b want %b", resp, e.resp); end
    n_cmp++; if (!e1) begin n_err++; $display("FAIL unmap_err1: got none want hresp=01 hready=0"); end
    n_cmp++; if (po !== 4'b0 || acc !== 0) begin n_err++; $display("FAIL unmap_psel: got %b/%0d want 0000/0", po, acc); end
  endtask

  task automatic test_bad_size_then_accept();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    rdata_cfg[1] = 32'hC0FF_EE01;
    sb.push_back('{resp: 2'b01, rdata: exp_hrdata, lat: 2});
    sb.push_back('{resp: 2'b00, rdata: 32'hC0FF_EE01, lat: 3});
    xfer(32'h0000_1000, 0, 32'h0, 3'd3, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || resp !== e.resp) begin n_err++; $display("FAIL size_err: got lat %0d resp %b want %0d/%b", lat, resp, e.lat, e.resp); end
    n_cmp++; if (po !== 4'b0) begin n_err++; $display("FAIL size_psel: got %b want 0000", po); end
    // Presented during ERR2, so it must be accepted straight away.
    xfer(32'h0000_1008, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    exp_hrdata = 32'hC0FF_EE01;
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL err2_accept_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata || resp !== e.resp) begin n_err++; $display("FAIL err2_accept_data: got %h/%b want %h/%b", rd, resp, e.rdata, e.resp); end
  endtask

  task automatic test_timeout();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    never_cfg[3] = 1; rdata_cfg[3] = 32'h3333_3333;
    sb.push_back('{resp: 2'b01, rdata: exp_hrdata, lat: 2 + TO + 1});
    xfer(32'h0000_3000, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (acc !== TO) begin n_err++; $display("FAIL tmo_access_cycles: got %0d want %0d", acc, TO); end
    n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL tmo_lat: got %0d want %0d", lat, e.lat); end
    n_cmp++; if (resp !== e.resp || !e1) begin n_err++; $display("FAIL tmo_resp: got %b err1=%0d want %b err1=1", resp, e1, e.resp); end
    n_cmp++; if (rd !== e.rdata) begin n_err++; $display("FAIL tmo_hrdata: got %h want %h", rd, e.rdata); end
    never_cfg[3] = 0;
    // Ready on the cycle the counter would expire: the response wins.
    wait_cfg[3] = TO - 1; rdata_cfg[3] = 32'h3333_7777;
    sb.push_back('{resp: 2'b00, rdata: 32'h3333_7777, lat: 2 + TO});
    xfer(32'h0000_3004, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    exp_hrdata = 32'h3333_7777;
    n_cmp++; if (lat !== e.lat || resp !== e.resp) begin n_err++; $display("FAIL tmo_edge: got lat %0d resp %b want %0d/%b", lat, resp, e.lat, e.resp); end
    n_cmp++; if (rd !== e.rdata) begin n_err++; $display("FAIL tmo_edge_rdata: got %h want %h", rd, e.rdata); end
    wait_cfg[3] = 0;
  endtask

  task automatic test_back_to_back();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    rdata_cfg[0] = 32'hA0A0_0001; wait_cfg[2] = 1;
    sb.push_back('{resp: 2'b00, rdata: 32'hA0A0_0001, lat: 3});
    sb.push_back('{resp: 2'b00, rdata: 32'hA0A0_0001, lat: 4 + 1});
    xfer(32'h0000_0010, 0, 32'h0, 3'd1, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    n_cmp++; if (lat !== e.lat || rd !== e.rdata) begin n_err++; $display("FAIL b2b_rd: got lat %0d data %h want %0d/%h", lat, rd, e.lat, e.rdata); end
    xfer(32'h0000_2020, 1, 32'h5555_AAAA, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    exp_hrdata = 32'hA0A0_0001;
    n_cmp++; if (lat !== e.lat || resp !== e.resp) begin n_err++; $display("FAIL b2b_wr: got lat %0d resp %b want %0d/%b", lat, resp, e.lat, e.resp); end
    n_cmp++; if (bus.pwdata !== 32'h5555_AAAA || po !== 4'b0100) begin n_err++; $display("FAIL b2b_wr_apb: got %h/%b want 5555aaaa/0100", bus.pwdata, po); end
    wait_cfg[2] = 0;
  endtask

  task automatic test_reset_access();
    int lat, acc; logic [1:0] resp; logic [31:0] rd; logic [NS-1:0] po, p1;
    bit e1, st, oh, tmo; exp_t e;
    wait_cfg[0] = 5;
    bus.hsels = 1; bus.haddrs = 32'h0000_0008; bus.hwrites = 1; bus.htranss = 2'b10;
    bus.hsizes = 3'd2; bus.hreadys = 1;
    @(posedge clk); @(negedge clk);
    bus.hsels = 0; bus.htranss = 2'b00; bus.hwdatas = 32'hA5A5_0000;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_cmp++; if (bus.penable !== 1'b1) begin n_err++; $display("FAIL rsta_in_access: got penable %b want 1", bus.penable); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_hrdata = '0;
    n_cmp++; if (bus.hreadyouts !== 1'b1 || bus.hresps !== 2'b00) begin n_err++; $display("FAIL rsta_ahb: got %b/%b want 1/00", bus.hreadyouts, bus.hresps); end
    n_cmp++; if (bus.hrdatas !== 32'h0) begin n_err++; $display("FAIL rsta_hrdata: got %h want 0", bus.hrdatas); end
    n_cmp++; if (bus.psel !== 4'b0 || bus.penable !== 1'b0) begin n_err++; $display("FAIL rsta_psel: got %b/%b want 0000/0", bus.psel, bus.penable); end
    n_cmp++; if (bus.paddr !== 32'h0 || bus.pwrite !== 1'b0 || bus.pwdata !== 32'h0) begin
      n_err++; $display("FAIL rsta_apb: got %h/%b/%h want 0/0/0", bus.paddr, bus.pwrite, bus.pwdata);
    end
    wait_cfg[0] = 0; rdata_cfg[2] = 32'h600D_F00D;
    sb.push_back('{resp: 2'b00, rdata: 32'h600D_F00D, lat: 3});
    xfer(32'h0000_2000, 0, 32'h0, 3'd2, lat, resp, rd, acc, po, p1, e1, st, oh, tmo);
    e = sb.pop_front();
    exp_hrdata = 32'h600D_F00D;
    n_cmp++; if (lat !== e.lat || resp !== e.resp || rd !== e.rdata) begin
      n_err++; $display("FAIL rsta_next: got lat %0d resp %b data %h want %0d/%b/%h", lat, resp, rd, e.lat, e.resp, e.rdata);
    end
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      rdata_cfg[k] = 32'hF000_0000 | 32'(k); wait_cfg[k] = 0; err_cfg[k] = 0; never_cfg[k] = 0;
    end
    test_reset();
    test_busy_idle();
    test_read_slave2();
    test_write_wait();
    test_slverr();
    test_unmapped();
    test_bad_size_then_accept();
    test_timeout();
    test_back_to_back();
    test_reset_access();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
